// File: rtl/johnson_pkg.sv
// Shared Johnson-ring helpers: code generation/decoding for a ring of width w,
// the monitor FSM state encoding and phase-index sizing.
package johnson_pkg;

    localparam int JN_MAX_W  = 16;
    localparam int JN_PH_W   = $clog2(2 * JN_MAX_W);

    typedef enum logic [1:0] {
        JN_SYNC  = 2'd0,
        JN_TRACK = 2'd1,
        JN_ERR   = 2'd2
    } jn_state_e;

    typedef struct packed {
        logic               legal;
        logic [JN_PH_W-1:0] phase;
    } jn_dec_t;

    // Phases up to w fill ones from the bottom; later phases clear them from the bottom.
    function automatic logic [JN_MAX_W-1:0] jn_code(input int p, input int w);
        logic [JN_MAX_W-1:0] c;
        c = '0;
        for (int b = 0; b < JN_MAX_W; b++) begin
            if (b >= w) begin
                c[b] = 1'b0;
            end else if (p <= w) begin
                c[b] = (b < p);
            end else begin
                c[b] = (b >= p - w);
            end
        end
        return c;
    endfunction

    function automatic jn_dec_t jn_decode(input logic [JN_MAX_W-1:0] code, input int w);
        jn_dec_t d;
        d = '0;
        for (int p = 0; p < 2 * JN_MAX_W; p++) begin
            if ((p < 2 * w) && (code == jn_code(p, w))) begin
                d.legal = 1'b1;
                d.phase = JN_PH_W'(p);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/johnson_seq_monitor_if.sv
// Revolution-event stream (valid/ready) from the monitor to its consumer.
interface johnson_seq_monitor_if #(
    parameter int CNT_W = 8
);
    logic [CNT_W-1:0] rev_data;
    logic             rev_vld;
    logic             rev_rdy;

    modport master (output rev_data, output rev_vld, input  rev_rdy);
    modport slave  (input  rev_data, input  rev_vld, output rev_rdy);
endinterface

// File: rtl/jsm_event_fifo.sv
// Small event FIFO: valid/ready pop at the head, push reports a drop when full
// and not popped in the same cycle.
module jsm_event_fifo #(
    parameter  int DEPTH = 2,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          drop,
    output logic [DW-1:0] head_data,
    output logic          head_vld,
    input  logic          pop_rdy
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic          full_s;
    logic          pop_s;
    logic          wr_s;

    // Handshake decode; a pop frees the slot the same-cycle push lands in.
    always_comb begin
        head_vld  = (cnt_r != {(AW+1){1'b0}});
        head_data = mem_r[rd_ptr_r];
        full_s    = (cnt_r == (AW+1)'(DEPTH));
        pop_s     = head_vld & pop_rdy;
        wr_s      = push & (~full_s | pop_s);
        drop      = push & full_s & ~pop_s;
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_s, pop_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson ring-code monitor: locks onto the phase, flags illegal steps, and
// streams revolution counts. Optional capture: JOHNSON_SEQ_MONITOR_ERR_CAPTURE_EN.
module johnson_seq_monitor
    import johnson_pkg::*;
#(
    parameter  int W           = 4,
    parameter  int CNT_W       = 8,
    parameter  int FIFO_DEPTH  = 2,
    parameter  int ALLOW_STALL = 1,
    localparam int PH_W        = $clog2(2 * W)
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [W-1:0]          i_q,
    input  logic                  i_q_vld,
    input  logic                  i_clr,
    output logic [PH_W-1:0]       o_phase,
    output logic                  o_locked,
    output logic                  o_err,
    output logic                  o_ovf,
    johnson_seq_monitor_if.master rev_if,
    output logic [2*W-1:0]        o_err_code
);

    localparam logic [1:0]      ST_SYNC  = 2'(JN_SYNC);
    localparam logic [1:0]      ST_TRACK = 2'(JN_TRACK);
    localparam logic [1:0]      ST_ERR   = 2'(JN_ERR);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * W - 1);

    logic [1:0]       state_r;
    logic [PH_W-1:0]  phase_r;
    logic             locked_r;
    logic             err_r;
    logic             ovf_r;
    logic [CNT_W-1:0] rev_cnt_r;

    jn_dec_t          dec_s;
    logic [PH_W-1:0]  next_ph_s;
    logic             sample_s;
    logic             succ_s;
    logic             hold_s;
    logic             to_err_s;
    logic             wrap_s;
    logic             drop_s;
    logic [CNT_W-1:0] head_data_s;
    logic             head_vld_s;

    // Classify the current sample against the tracked phase.
    always_comb begin
        dec_s     = jn_decode(JN_MAX_W'(i_q), W);
        next_ph_s = (phase_r == PH_LAST) ? {PH_W{1'b0}} : (phase_r + PH_W'(1));
        sample_s  = i_q_vld & ~i_clr;
        succ_s    = dec_s.legal & (dec_s.phase == JN_PH_W'(next_ph_s));
        hold_s    = dec_s.legal & (dec_s.phase == JN_PH_W'(phase_r)) & (ALLOW_STALL != 0);
        if (sample_s && (state_r == ST_TRACK)) begin
            to_err_s = ~succ_s & ~hold_s;
            wrap_s   = succ_s & (phase_r == PH_LAST);
        end else begin
            to_err_s = 1'b0;
            wrap_s   = 1'b0;
        end
    end

    // Lock/track/error state machine and sticky flags; clear wins over everything.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r  <= ST_SYNC;
            phase_r  <= '0;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (i_clr) begin
            state_r  <= ST_SYNC;
            locked_r <= 1'b0;
            err_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_SYNC: begin
                    if (sample_s && dec_s.legal) begin
                        state_r  <= ST_TRACK;
                        phase_r  <= dec_s.phase[PH_W-1:0];
                        locked_r <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (to_err_s) begin
                        state_r  <= ST_ERR;
                        locked_r <= 1'b0;
                        err_r    <= 1'b1;
                    end else if (sample_s && succ_s) begin
                        phase_r <= dec_s.phase[PH_W-1:0];
                    end
                end
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
                default: begin
                    state_r  <= ST_SYNC;
                    locked_r <= 1'b0;
                end
            endcase
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Revolution counter survives i_clr; it advances even when the event is dropped.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rev_cnt_r <= '0;
        end else if (wrap_s) begin
            rev_cnt_r <= rev_cnt_r + CNT_W'(1);
        end
    end

    jsm_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (CNT_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_arst),
        .push      (wrap_s),
        .push_data (rev_cnt_r + CNT_W'(1)),
        .drop      (drop_s),
        .head_data (head_data_s),
        .head_vld  (head_vld_s),
        .pop_rdy   (rev_if.rev_rdy)
    );

    assign rev_if.rev_data = head_data_s;
    assign rev_if.rev_vld  = head_vld_s;
    assign o_phase         = phase_r;
    assign o_locked        = locked_r;
    assign o_err           = err_r;
    assign o_ovf           = ovf_r;

`ifdef JOHNSON_SEQ_MONITOR_ERR_CAPTURE_EN
    logic [2*W-1:0] err_code_r;

    // Only one TRACK->ERR can occur between clears, so the first error is what stays.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            err_code_r <= '0;
        end else if (i_clr) begin
            err_code_r <= '0;
        end else if (to_err_s) begin
            err_code_r <= {W'(jn_code(int'(phase_r), W)), i_q};
        end
    end

    assign o_err_code = err_code_r;
`else
    assign o_err_code = {(2*W){1'b0}};
`endif

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Scoreboard bench for johnson_seq_monitor (W=4); a second instance runs with
// ALLOW_STALL=0 on the same inputs.
module tb_johnson_seq_monitor;

    logic       clk = 1'b0;
    logic       arst;
    logic [3:0] q;
    logic       q_vld;
    logic       clr;
    logic [2:0] phase, phase0;
    logic       locked, err, ovf, locked0, err0, ovf0;
    logic [7:0] err_code, err_code0;

    johnson_seq_monitor_if #(.CNT_W(8)) rev_if ();
    johnson_seq_monitor_if #(.CNT_W(8)) rev_if0 ();

    johnson_seq_monitor #(.W(4), .CNT_W(8), .FIFO_DEPTH(2), .ALLOW_STALL(1)) dut (
        .i_clk(clk), .i_arst(arst), .i_q(q), .i_q_vld(q_vld), .i_clr(clr),
        .o_phase(phase), .o_locked(locked), .o_err(err), .o_ovf(ovf),
        .rev_if(rev_if), .o_err_code(err_code)
    );

    johnson_seq_monitor #(.W(4), .CNT_W(8), .FIFO_DEPTH(2), .ALLOW_STALL(0)) dut0 (
        .i_clk(clk), .i_arst(arst), .i_q(q), .i_q_vld(q_vld), .i_clr(clr),
        .o_phase(phase0), .o_locked(locked0), .o_err(err0), .o_ovf(ovf0),
        .rev_if(rev_if0), .o_err_code(err_code0)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] sb_q[$];
    logic [3:0] seq[8];
    int         last_ph;
    int         rev_model;
    logic       exp_ovf;
    logic [7:0] exp_code;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    // Consumer side: every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (arst === 1'b0 && rev_if.rev_vld === 1'b1 && rev_if.rev_rdy === 1'b1) begin
            if (sb_q.size() == 0) check_eq("rev_unexpected", 32'(rev_if.rev_data), 32'hFFFF_FFFF);
            else check_eq("rev_data", 32'(rev_if.rev_data), 32'(sb_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic smp(input logic [3:0] code, input logic v);
        q     = code;
        q_vld = v;
        tick();
        q_vld = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        last_ph = -1;
    endtask

    // Drive the code of phase p while tracking; a 7->0 step is one revolution.
    task automatic step_ph(input int p);
        if (last_ph == 7 && p == 0) begin
            rev_model++;
            if (sb_q.size() < 2) sb_q.push_back(8'(rev_model));
            else exp_ovf = 1'b1;
        end
        last_ph = p;
        smp(seq[p], 1'b1);
        check_eq("phase", 32'(phase), 32'(p));
        check_eq("locked", 32'(locked), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"}, 32'(phase), 32'd0);
        check_eq({tag, "_locked"}, 32'(locked), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_ovf"}, 32'(ovf), 32'd0);
        check_eq({tag, "_rev_vld"}, 32'(rev_if.rev_vld), 32'd0);
        check_eq({tag, "_rev_data"}, 32'(rev_if.rev_data), 32'd0);
        check_eq({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
`ifdef JOHNSON_SEQ_MONITOR_ERR_CAPTURE_EN
        exp_code = 8'h36;
`else
        exp_code = 8'h00;
`endif
        arst = 1'b1; q = 4'h0; q_vld = 1'b0; clr = 1'b0;
        rev_if.rev_rdy = 1'b0; rev_if0.rev_rdy = 1'b1;
        last_ph = -1; rev_model = 0; exp_ovf = 1'b0;
        #1;
        check_all_zero("rst");
        #20;
        arst = 1'b0;
        tick();

        // Two full revolutions of the legal sequence with the consumer ready.
        rev_if.rev_rdy = 1'b1;
        for (int i = 0; i < 17; i++) step_ph(i % 8);
        tick(); tick();
        check_eq("t1_err", 32'(err), 32'd0);
        check_eq("t1_rev_model", 32'(rev_model), 32'd2);
        check_eq("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // Illegal code while locked at phase 2.
        step_ph(1); step_ph(2);
        smp(4'h6, 1'b1);
        check_eq("t2_err", 32'(err), 32'd1);
        check_eq("t2_locked", 32'(locked), 32'd0);
        check_eq("t2_phase_hold", 32'(phase), 32'd2);
        check_eq("t2_err_code", 32'(err_code), 32'(exp_code));
        pulse_clr();
        check_eq("t2_clr_err", 32'(err), 32'd0);
        check_eq("t2_clr_code", 32'(err_code), 32'd0);
        smp(4'h5, 1'b1);
        check_eq("t2_sync_err", 32'(err), 32'd0);
        check_eq("t2_sync_locked", 32'(locked), 32'd0);

        // Repeated code: legal hold vs. error without stall allowance.
        smp(seq[3], 1'b1);
        check_eq("t3_locked0", 32'(locked0), 32'd1);
        smp(seq[3], 1'b1);
        check_eq("t3_err", 32'(err), 32'd0);
        check_eq("t3_phase", 32'(phase), 32'd3);
        check_eq("t3_locked", 32'(locked), 32'd1);
        check_eq("t3_err0", 32'(err0), 32'd1);
        check_eq("t3_locked0_drop", 32'(locked0), 32'd0);
        pulse_clr();
        check_eq("t3_clr_err0", 32'(err0), 32'd0);

        // Three revolutions with the consumer stalled: two buffered, one dropped.
        rev_if.rev_rdy = 1'b0;
        step_ph(0);
        for (int r = 0; r < 3; r++)
            for (int p = 1; p <= 8; p++) step_ph(p % 8);
        check_eq("t4_ovf", 32'(ovf), 32'(exp_ovf));
        check_eq("t4_sb_size", 32'(sb_q.size()), 32'd2);
        check_eq("t4_rev_vld", 32'(rev_if.rev_vld), 32'd1);
        check_eq("t4_head", 32'(rev_if.rev_data), 32'(sb_q[0]));
        tick();
        check_eq("t4_head_stable", 32'(rev_if.rev_data), 32'(sb_q[0]));
        rev_if.rev_rdy = 1'b1;
        tick(); tick(); tick();
        check_eq("t4_drained", 32'(sb_q.size()), 32'd0);
        check_eq("t4_rev_vld_low", 32'(rev_if.rev_vld), 32'd0);
        check_eq("t4_ovf_sticky", 32'(ovf), 32'd1);
        pulse_clr();
        exp_ovf = 1'b0;
        check_eq("t4_ovf_clr", 32'(ovf), 32'd0);
        step_ph(0);
        for (int p = 1; p <= 8; p++) step_ph(p % 8);
        tick(); tick();
        check_eq("t4_next_rev", 32'(rev_model), 32'd6);
        check_eq("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset mid-revolution, then relock at phase 6.
        for (int p = 1; p <= 5; p++) step_ph(p);
        @(posedge clk);
        #3;
        arst = 1'b1;
        #1;
        check_all_zero("t5_rst");
        sb_q.delete();
        rev_model = 0;
        last_ph = -1;
        #10;
        arst = 1'b0;
        tick();
        step_ph(6);
        check_eq("t5_err", 32'(err), 32'd0);
        step_ph(7); step_ph(0);
        tick(); tick();
        check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        // Invalid samples carrying garbage are ignored.
        step_ph(1);
        smp(4'hA, 1'b0);
        check_eq("t6_phase", 32'(phase), 32'd1);
        check_eq("t6_locked", 32'(locked), 32'd1);
        check_eq("t6_err", 32'(err), 32'd0);
        smp(4'h6, 1'b0);
        check_eq("t6_err0", 32'(err0), 32'd0);
        step_ph(2);
        check_eq("t6_err_end", 32'(err), 32'd0);

        tick(); tick();
        check_eq("end_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
